pipeline_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage MIPS pipeline. It drives stall and flush controls
//  for the Fetch, Decode/Execute and Execute/Memory pipeline registers, and the Execute-stage

---
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller bundle between pipeline datapath and controller
//
// Purpose: groups the pipeline-stage register numbers and control bits consumed
// by the hazard controller together with the stall/flush/forward controls it returns.
// Modports:
//   master - the pipeline datapath: drives stage info, receives controls
//   slave  - the hazard controller: receives stage info, drives controls
// Parameter CNT_W sets the width of the StallCycles performance counter.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs_D, Rt_D, Rs_E, Rt_E;
  logic [4:0]       WriteReg_E, WriteReg_M, WriteReg_W;
  logic             RegWrite_E, RegWrite_M, RegWrite_W;
  logic             MemtoReg_E, PCSrc_E, MulStart_E;
  logic             StallF, StallD, StallE;
  logic             FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MulBusy;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, PCSrc_E, MulStart_E,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MulBusy, StallCycles
  );

  modport slave (
    input  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, PCSrc_E, MulStart_E,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MulBusy, StallCycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage MIPS hazard controller: forwarding, stalls, flushes, multiply hold
//
// Purpose: resolves load-use stalls and taken-branch flushes, selects Execute-stage
// forwarding sources, holds a multi-cycle multiply in Execute with a RUN/BUSY FSM
// and counts cycles in which the PC was held.
// Ports:
//   clk    - pipeline clock, rising edge
//   reset  - synchronous, active-high reset
//   hz     - slave side of pipeline_hazard_ctrl_if (stage info in, controls out)
// Parameters:
//   MUL_CYCLES - cycles a multiply occupies Execute (1 = no stall)
//   CNT_W      - width of the wrapping StallCycles counter
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  // Counter needs to hold MUL_CYCLES-2; keep at least one bit for the degenerate cases.
  localparam int            CW        = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam bit            MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [CW-1:0] CNT_INIT  = MUL_MULTI ? CW'(MUL_CYCLES - 2) : '0;

  typedef enum logic {RUN, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cycles;
  logic             mulstall, lwstall;
  logic             stall_f, stall_d, stall_e;
  logic             flush_d, flush_e, flush_m;
  logic [1:0]       fwd_a, fwd_b;

  // The Execute destination is not needed by this controller; it is kept in the
  // bundle so the datapath wiring stays uniform across stages.
  logic unused_write_reg_e;
  assign unused_write_reg_e = ^hz.WriteReg_E;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       rw_m, input logic [4:0] wr_m,
    input logic       rw_w, input logic [4:0] wr_w
  );
    if (rw_m && wr_m != 5'd0 && wr_m == src)      return 2'b10;
    else if (rw_w && wr_w != 5'd0 && wr_w == src) return 2'b01;
    else                                          return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // RUN cycle that sees the multiply plus the non-zero BUSY cycles are stalled;
  // the BUSY cnt==0 cycle lets the multiply advance, giving MUL_CYCLES in Execute.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mulstall  = 1'b0;
    case (state)
      RUN: begin
        if (hz.MulStart_E && MUL_MULTI) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
          mulstall  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt  = cnt - CW'(1);
          mulstall = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign lwstall = hz.MemtoReg_E && hz.RegWrite_E && hz.Rt_E != 5'd0 &&
                   (hz.Rt_E == hz.Rs_D || hz.Rt_E == hz.Rt_D);

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      fwd_a = fwd_sel(hz.Rs_E, hz.RegWrite_M, hz.WriteReg_M, hz.RegWrite_W, hz.WriteReg_W);
      fwd_b = fwd_sel(hz.Rt_E, hz.RegWrite_M, hz.WriteReg_M, hz.RegWrite_W, hz.WriteReg_W);
      if (mulstall) begin
        // Freeze everything up to Execute; Memory receives bubbles meanwhile.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (hz.PCSrc_E) begin
        // Taken branch squashes the load-dependent instruction, so no stall needed.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lwstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        stall_cycles <= '0;
    else if (stall_f) stall_cycles <= stall_cycles + CNT_W'(1);
  end

  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushM      = flush_m;
  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.MulBusy     = (state == BUSY) && !reset;
  assign hz.StallCycles = stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Three builds sharing the same stimulus: nominal, single-cycle multiply, 4-bit counter.
  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_n ();
  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if_w ();

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(32)) u_n (.clk(clk), .reset(reset), .hz(if_n));
  pipeline_hazard_ctrl #(.MUL_CYCLES(1), .CNT_W(32)) u_1 (.clk(clk), .reset(reset), .hz(if_1));
  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(4))  u_w (.clk(clk), .reset(reset), .hz(if_w));

  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w, m2r_e, pcsrc_e, mul_e;

  always_comb begin
    if_n.Rs_D = rs_d; if_n.Rt_D = rt_d; if_n.Rs_E = rs_e; if_n.Rt_E = rt_e;
    if_n.WriteReg_E = wr_e; if_n.WriteReg_M = wr_m; if_n.WriteReg_W = wr_w;
    if_n.RegWrite_E = rw_e; if_n.RegWrite_M = rw_m; if_n.RegWrite_W = rw_w;
    if_n.MemtoReg_E = m2r_e; if_n.PCSrc_E = pcsrc_e; if_n.MulStart_E = mul_e;
  end
  always_comb begin
    if_1.Rs_D = rs_d; if_1.Rt_D = rt_d; if_1.Rs_E = rs_e; if_1.Rt_E = rt_e;
    if_1.WriteReg_E = wr_e; if_1.WriteReg_M = wr_m; if_1.WriteReg_W = wr_w;
    if_1.RegWrite_E = rw_e; if_1.RegWrite_M = rw_m; if_1.RegWrite_W = rw_w;
    if_1.MemtoReg_E = m2r_e; if_1.PCSrc_E = pcsrc_e; if_1.MulStart_E = mul_e;
  end
  always_comb begin
    if_w.Rs_D = rs_d; if_w.Rt_D = rt_d; if_w.Rs_E = rs_e; if_w.Rt_E = rt_e;
    if_w.WriteReg_E = wr_e; if_w.WriteReg_M = wr_m; if_w.WriteReg_W = wr_w;
    if_w.RegWrite_E = rw_e; if_w.RegWrite_M = rw_m; if_w.RegWrite_W = rw_w;
    if_w.MemtoReg_E = m2r_e; if_w.PCSrc_E = pcsrc_e; if_w.MulStart_E = mul_e;
  end

  // ctl packing: {StallF,StallD,StallE, FlushD,FlushE,FlushM, MulBusy, ForwardAE, ForwardBE}
  localparam logic [10:0] C_RST  = 11'b000_111_0_00_00;
  localparam logic [10:0] C_IDLE = 11'b000_000_0_00_00;
  localparam logic [10:0] C_LW   = 11'b110_010_0_00_00;
  localparam logic [10:0] C_BR   = 11'b000_110_0_00_00;
  localparam logic [10:0] C_MUL0 = 11'b111_001_0_00_00;
  localparam logic [10:0] C_MULB = 11'b111_001_1_00_00;
  localparam logic [10:0] C_MULE = 11'b000_000_1_00_00;

  typedef struct {
    string       tag;
    int          sel;
    logic [10:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic logic [10:0] ctl_of(input int sel);
    case (sel)
      0: return {if_n.StallF, if_n.StallD, if_n.StallE, if_n.FlushD, if_n.FlushE, if_n.FlushM,
                 if_n.MulBusy, if_n.ForwardAE, if_n.ForwardBE};
      1: return {if_1.StallF, if_1.StallD, if_1.StallE, if_1.FlushD, if_1.FlushE, if_1.FlushM,
                 if_1.MulBusy, if_1.ForwardAE, if_1.ForwardBE};
      default: return {if_w.StallF, if_w.StallD, if_w.StallE, if_w.FlushD, if_w.FlushE, if_w.FlushM,
                 if_w.MulBusy, if_w.ForwardAE, if_w.ForwardBE};
    endcase
  endfunction

  function automatic logic [31:0] cnt_of(input int sel);
    case (sel)
      0:       return if_n.StallCycles;
      1:       return if_1.StallCycles;
      default: return {28'd0, if_w.StallCycles};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [10:0] ctl, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ctl = ctl; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Sample at the falling edge, drain the scoreboard, then move to just after the next rising edge.
  task automatic tick();
    exp_t        e;
    logic [10:0] oc;
    logic [31:0] on;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      oc = ctl_of(e.sel);
      on = cnt_of(e.sel);
      checks++;
      assert (oc === e.ctl) else begin
        fails++;
        $error("FAIL %s.ctl observed=%b expected=%b", e.tag, oc, e.ctl);
      end
      checks++;
      assert (on === e.cnt) else begin
        fails++;
        $error("FAIL %s.cnt observed=%0d expected=%0d", e.tag, on, e.cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wr_e = 0; wr_m = 0; wr_w = 0;
    rw_e = 0; rw_m = 0; rw_w = 0; m2r_e = 0; pcsrc_e = 0; mul_e = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    expect_out("reset", 0, C_RST, 0);
    expect_out("reset_w", 2, C_RST, 0);
    tick();

    // T1 forwarding
    reset = 1'b0;
    rs_e = 5; rt_e = 5; wr_m = 5; rw_m = 1; wr_w = 5; rw_w = 1;
    expect_out("fwd_mem", 0, 11'b000_000_0_10_10, 0);
    tick();
    rw_m = 0;
    expect_out("fwd_wb", 0, 11'b000_000_0_01_01, 0);
    tick();
    rs_e = 0; rt_e = 0; wr_m = 0; wr_w = 0; rw_m = 1; rw_w = 1;
    expect_out("fwd_r0", 0, C_IDLE, 0);
    tick();
    rs_e = 5; wr_m = 5; rt_e = 9; wr_w = 9;
    expect_out("fwd_mix", 0, 11'b000_000_0_10_01, 0);
    tick();

    // T2 load-use
    clear_inputs();
    m2r_e = 1; rw_e = 1; rt_e = 8; rt_d = 8;
    expect_out("lw_rt", 0, C_LW, 0);
    tick();
    m2r_e = 0;
    expect_out("lw_done", 0, C_IDLE, 1);
    tick();
    m2r_e = 1; rt_e = 0; rt_d = 0;
    expect_out("lw_r0", 0, C_IDLE, 1);
    tick();
    rt_e = 3; rs_d = 3;
    expect_out("lw_rs", 0, C_LW, 1);
    tick();

    // T3 branch overrides load-use
    pcsrc_e = 1;
    expect_out("branch", 0, C_BR, 2);
    tick();
    clear_inputs();
    expect_out("branch_after", 0, C_IDLE, 2);
    tick();

    // T4 multiply held: three stalled cycles then one advancing BUSY cycle
    mul_e = 1;
    expect_out("mul_c0", 0, C_MUL0, 2);
    expect_out("mul1_c0", 1, C_IDLE, 2);
    tick();
    pcsrc_e = 1;  // multiply hold outranks a taken branch
    expect_out("mul_c1", 0, C_MULB, 3);
    tick();
    pcsrc_e = 0;
    expect_out("mul_c2", 0, C_MULB, 4);
    expect_out("mul1_c2", 1, C_IDLE, 2);
    tick();
    expect_out("mul_c3", 0, C_MULE, 5);
    expect_out("mul1_c3", 1, C_IDLE, 2);
    tick();
    mul_e = 0;
    expect_out("mul_idle", 0, C_IDLE, 5);
    tick();

    // T5 reset while BUSY with cnt=1, multiply request still present afterwards
    mul_e = 1;
    expect_out("rm_c0", 0, C_MUL0, 5);
    tick();
    expect_out("rm_c1", 0, C_MULB, 6);
    tick();
    reset = 1'b1;
    expect_out("rm_reset", 0, C_RST, 7);
    tick();
    reset = 1'b0;
    expect_out("rm_new0", 0, C_MUL0, 0);
    tick();
    expect_out("rm_new1", 0, C_MULB, 1);
    tick();
    expect_out("rm_new2", 0, C_MULB, 2);
    tick();
    expect_out("rm_end", 0, C_MULE, 3);
    tick();
    mul_e = 0;
    expect_out("rm_idle", 0, C_IDLE, 3);
    tick();

    // T6 4-bit counter wraps after 16 stall cycles
    reset = 1'b1;
    expect_out("wrap_reset", 2, C_RST, 3);
    tick();
    reset = 1'b0;
    m2r_e = 1; rw_e = 1; rt_e = 8; rt_d = 8;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) expect_out("wrap_at16", 2, C_LW, 0);
      tick();
    end
    clear_inputs();
    expect_out("wrap_final", 2, C_IDLE, 1);
    expect_out("nowrap_final", 0, C_IDLE, 17);
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
